// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the FP divider writeback tracker.
package fp_div_pkg;

    localparam int unsigned LATENCY_DEFAULT = 28;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_INF = 8'hFF;

    // fflags bit positions {NV,DZ,OF,UF,NX}
    localparam int unsigned FLAGS_W = 5;
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef struct packed {
        logic [31:0]        data;
        logic [FLAGS_W-1:0] flags;
    } wb_payload_t;

    localparam int unsigned WB_PAYLOAD_W = $bits(wb_payload_t);

    // Writeback entry is {rd, data, flags}.
    function automatic int unsigned wb_entry_w(input int unsigned tag_w);
        return tag_w + WB_PAYLOAD_W;
    endfunction

    typedef struct packed {
        logic is_nan;
        logic is_snan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    typedef struct packed {
        logic        en;
        wb_payload_t res;
    } fp_ovr_t;

    // Denormals classify as zero because the divider flushes them.
    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        c.is_nan  = (x[30:23] == FP_EXP_INF) && (x[22:0] != '0);
        c.is_snan = c.is_nan && !x[22];
        c.is_inf  = (x[30:23] == FP_EXP_INF) && (x[22:0] == '0);
        c.is_zero = (x[30:23] == '0);
        return c;
    endfunction

    function automatic fp_ovr_t special_case(input logic [31:0] a, input logic [31:0] b);
        fp_ovr_t   o;
        fp_class_t ca;
        fp_class_t cb;
        logic      s;
        ca = classify(a);
        cb = classify(b);
        s  = a[31] ^ b[31];
        o  = '0;
        if (ca.is_nan || cb.is_nan) begin
            o.en               = 1'b1;
            o.res.data         = FP_QNAN;
            o.res.flags[FLAG_NV] = ca.is_snan | cb.is_snan;
        end else if ((ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
            o.en               = 1'b1;
            o.res.data         = FP_QNAN;
            o.res.flags[FLAG_NV] = 1'b1;
        end else if (ca.is_inf) begin
            o.en       = 1'b1;
            o.res.data = {s, FP_EXP_INF, 23'h0};
        end else if (cb.is_zero) begin
            o.en               = 1'b1;
            o.res.data         = {s, FP_EXP_INF, 23'h0};
            o.res.flags[FLAG_DZ] = 1'b1;
        end else if (cb.is_inf || ca.is_zero) begin
            o.en       = 1'b1;
            o.res.data = {s, 31'h0};
        end
        // Only invalid and divide-by-zero are ever raised here.
        o.res.flags[FLAG_OF] = 1'b0;
        o.res.flags[FLAG_UF] = 1'b0;
        o.res.flags[FLAG_NX] = 1'b0;
        return o;
    endfunction

endpackage

// File: rtl/fp_div_wb_tracker_if.sv
// Issue, divider and writeback signals of the FP divider tracker.
interface fp_div_wb_tracker_if #(
    parameter int unsigned TAG_W = 5
);
    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      issue_a;
    logic [31:0]      issue_b;
    logic [TAG_W-1:0] issue_rd;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic [31:0]      div_result;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_rd;
    logic [31:0]      wb_data;
    logic [4:0]       wb_flags;
    logic             busy;

    modport slave (
        input  issue_valid, issue_a, issue_b, issue_rd, div_result, wb_ready,
        output issue_ready, div_a, div_b, wb_valid, wb_rd, wb_data, wb_flags, busy
    );

    modport master (
        output issue_valid, issue_a, issue_b, issue_rd, div_result, wb_ready,
        input  issue_ready, div_a, div_b, wb_valid, wb_rd, wb_data, wb_flags, busy
    );
endinterface

// File: rtl/fp_div_wb_fifo.sv
// In-order writeback FIFO; Depth must be a power of two so pointers wrap naturally.
module fp_div_wb_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 42
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             push_en, pop_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PtrW+1)'(Depth));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    // Next-state: write at tail, advance pointers, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + (PtrW+1)'(push_en) - (PtrW+1)'(pop_en);
    end

    // State registers; storage is cleared so outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/fp_div_wb_tracker.sv
// Launches divide ops into the free-running divider, tracks them with a tag delay line,
// applies IEEE special-case overrides and queues results for FP-regfile writeback.
module fp_div_wb_tracker
    import fp_div_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEFAULT,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 5
) (
    input logic                clk,
    input logic                rst_n,
    fp_div_wb_tracker_if.slave bus
);
    localparam int unsigned CntW   = $clog2(DEPTH) + 1;
    localparam int unsigned EntryW = wb_entry_w(TAG_W);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] rd;
        fp_ovr_t          ovr;
    } tag_t;

    logic [31:0]     div_a_q, div_a_d, div_b_q, div_b_d;
    tag_t            dl_q [LATENCY+1];
    tag_t            dl_d [LATENCY+1];
    logic [CntW-1:0] inflight_q, inflight_d, fifo_cnt;
    logic [CntW:0]   occ;
    logic            accept, push, pop, fifo_full, fifo_empty;
    tag_t            tail;
    wb_payload_t     push_pl;
    logic [EntryW-1:0] push_entry, head_entry;

    // Credits cover both in-flight and buffered ops, so the FIFO can never overflow.
    assign occ             = {1'b0, inflight_q} + {1'b0, fifo_cnt};
    assign bus.issue_ready = occ < (CntW+1)'(DEPTH);
    assign accept          = bus.issue_valid && bus.issue_ready;
    assign bus.busy        = (occ != '0);
    assign bus.div_a       = div_a_q;
    assign bus.div_b       = div_b_q;

    // Tail of the delay line lines up with div_result holding that op's quotient.
    assign tail         = dl_q[LATENCY];
    assign push         = tail.vld;
    assign push_pl.data  = tail.ovr.en ? tail.ovr.res.data : bus.div_result;
    assign push_pl.flags = tail.ovr.res.flags;
    assign push_entry   = {tail.rd, push_pl};
    assign pop          = !fifo_empty && bus.wb_ready;

    assign bus.wb_valid = !fifo_empty;
    assign {bus.wb_rd, bus.wb_data, bus.wb_flags} = head_entry;

    // Next-state: operand launch, delay-line shift with classified tag, credit count.
    always_comb begin
        div_a_d = div_a_q;
        div_b_d = div_b_q;
        dl_d[0] = '0;
        if (accept) begin
            div_a_d     = bus.issue_a;
            div_b_d     = bus.issue_b;
            dl_d[0].vld = 1'b1;
            dl_d[0].rd  = bus.issue_rd;
            dl_d[0].ovr = special_case(bus.issue_a, bus.issue_b);
        end
        for (int i = 1; i <= LATENCY; i++) dl_d[i] = dl_q[i-1];
        inflight_d = inflight_q + CntW'(accept) - CntW'(push);
    end

    // Launch registers, delay line and in-flight counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a_q    <= '0;
            div_b_q    <= '0;
            inflight_q <= '0;
            for (int i = 0; i <= LATENCY; i++) dl_q[i] <= '0;
        end else begin
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            inflight_q <= inflight_d;
            dl_q       <= dl_d;
        end
    end

    fp_div_wb_fifo #(
        .Depth (DEPTH),
        .Width (EntryW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // A tail push into a full FIFO without a same-cycle pop means the credits broke.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        (push && fifo_full) |-> pop);
endmodule
